// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use and branch-operand stalls, plus a
// multi-cycle mult/div occupancy FSM that freezes the front end while it runs.
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegAddrE,
    input  logic [4:0] writeRegAddrM,
    input  logic       Regfile_weE,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       branchD,
    input  logic       branchTakenD,
    input  logic       mdStartE,
    input  logic       mdOpE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       mdBusy,
    output logic       mdDoneE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    md_state_t  r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;

    logic w_lwstall;
    logic w_brstall;
    logic w_brE_hit;
    logic w_brM_hit;
    logic w_mdstall;
    logic w_front_stall;

    // Hazard detection; register 0 is hardwired and never a real dependency
    always_comb begin
        w_lwstall = memToRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
        w_brE_hit = Regfile_weE && (writeRegAddrE != 5'd0) &&
                    ((writeRegAddrE == rsD) || (writeRegAddrE == rtD));
        w_brM_hit = memToRegM && (writeRegAddrM != 5'd0) &&
                    ((writeRegAddrM == rsD) || (writeRegAddrM == rtD));
        w_brstall = branchD && (w_brE_hit || w_brM_hit);
    end

    // The start cycle itself stalls, so N total stall cycles = 1 + (N-1) in BUSY
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (mdStartE) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = mdOpE ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt == 6'd1) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            DONE: begin
                // Same instruction is still in E this cycle; don't restart on it
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are forced low during reset regardless of inputs or state
    always_comb begin
        w_mdstall     = (r_state == BUSY) || ((r_state == IDLE) && mdStartE);
        w_front_stall = w_lwstall || w_brstall || w_mdstall;

        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        mdBusy  = 1'b0;
        mdDoneE = 1'b0;
        if (rst_n) begin
            stallF  = w_front_stall;
            stallD  = w_front_stall;
            stallE  = w_mdstall;
            flushM  = w_mdstall;
            // ID/EX is held during mult/div, so it must not also be bubbled
            flushE  = (w_lwstall || w_brstall) && !w_mdstall;
            flushD  = branchTakenD && !w_front_stall;
            mdBusy  = w_mdstall;
            mdDoneE = (r_state == DONE);
        end
    end

endmodule
